// File: rtl/mem_dump_pkg.sv
// rtl/mem_dump_pkg.sv - shared types and sizes for the BRAM dump reader
package mem_dump_pkg;

    localparam int MEM_WID    = 72;
    localparam int MEM_DEPTH  = 2048;
    localparam int MEM_AW     = $clog2(MEM_DEPTH);
    localparam int SKID_DEPTH = 2;
    localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    typedef struct packed {
        logic [MEM_WID-1:0] data;
        logic [MEM_AW-1:0]  addr;
        logic               last;
    } beat_t;

endpackage

// File: rtl/mem_dump_skid.sv
// rtl/mem_dump_skid.sv - two-entry FIFO holding RAM words until the stream accepts them
module mem_dump_skid
    import mem_dump_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  beat_t            push_beat,
    input  logic             pop,
    output beat_t            head,
    output logic             head_valid,
    output logic [OCC_W-1:0] occ
);

    beat_t slot0, slot1;

    // slot0 is always the head; pop is only ever requested while occ != 0
    always_ff @(posedge clk) begin
        if (reset) begin
            slot0 <= '0;
            slot1 <= '0;
            occ   <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == '0) slot0 <= push_beat;
                    else           slot1 <= push_beat;
                    occ <= occ + 1'b1;
                end
                2'b01: begin
                    slot0 <= slot1;
                    occ   <= occ - 1'b1;
                end
                2'b11: begin
                    if (occ == OCC_W'(1)) begin
                        slot0 <= push_beat;
                    end else begin
                        slot0 <= slot1;
                        slot1 <= push_beat;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head       = slot0;
    assign head_valid = (occ != '0);

endmodule

// File: rtl/mem_dump_reader.sv
// rtl/mem_dump_reader.sv - sweeps a BRAM address range onto a valid/ready stream with XOR checksum
module mem_dump_reader
    import mem_dump_pkg::*;
#(
    parameter int WID_MEM   = MEM_WID,
    parameter int DEPTH_MEM = MEM_DEPTH,
    parameter int ADDR_W    = MEM_AW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [ADDR_W-1:0]  first_addr,
    input  logic [ADDR_W-1:0]  last_addr,
    output logic [ADDR_W-1:0]  raddr,
    input  logic [WID_MEM-1:0] rdata,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WID_MEM-1:0] m_data,
    output logic [ADDR_W-1:0]  m_addr,
    output logic               m_last,
    output logic               busy,
    output logic               done,
    output logic [WID_MEM-1:0] checksum
);

    state_t            state, state_next;
    logic [ADDR_W-1:0] first_r, last_r, tag_addr;
    logic              addr_ok, inflight, tag_last;
    logic              issue, pop, accept_start;
    logic [OCC_W-1:0]  occ;
    logic [OCC_W:0]    pending;
    beat_t             push_beat, head;
    logic              head_valid;

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == ADDR_W'(DEPTH_MEM - 1)) ? '0 : a + 1'b1;
    endfunction

    // raddr is presented during the issue cycle; the RAM registers it at the
    // following edge, so only one read is ever outstanding beyond the FIFO.
    assign pop     = head_valid && m_ready;
    assign pending = {1'b0, occ} + (OCC_W + 1)'(inflight);
    assign issue   = (state == RUN) && addr_ok &&
                     (pending < (OCC_W + 1)'(SKID_DEPTH) + (OCC_W + 1)'(pop));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        busy         = 1'b0;
        done         = 1'b0;
        accept_start = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_next   = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (issue && raddr == last_r) state_next = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (pop && head.last) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            raddr    <= '0;
            first_r  <= '0;
            last_r   <= '0;
            addr_ok  <= 1'b0;
            inflight <= 1'b0;
            tag_addr <= '0;
            tag_last <= 1'b0;
            checksum <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                tag_addr <= raddr;
                tag_last <= (raddr == last_r);
                if (raddr != last_r) raddr <= next_addr(raddr);
            end
            if (state == RUN && !addr_ok) begin
                raddr   <= first_r;
                addr_ok <= 1'b1;
            end
            if (accept_start) begin
                first_r  <= first_addr;
                last_r   <= last_addr;
                addr_ok  <= 1'b0;
                checksum <= '0;
            end else if (pop) begin
                checksum <= checksum ^ head.data;
            end
        end
    end

    always_comb begin
        push_beat      = '0;
        push_beat.data = rdata;
        push_beat.addr = tag_addr;
        push_beat.last = tag_last;
    end

    mem_dump_skid u_skid (
        .clk        (clk),
        .reset      (reset),
        .push       (inflight),
        .push_beat  (push_beat),
        .pop        (pop),
        .head       (head),
        .head_valid (head_valid),
        .occ        (occ)
    );

    assign m_valid = head_valid;
    assign m_data  = head.data;
    assign m_addr  = head.addr;
    assign m_last  = head.last;

endmodule

// File: tb/tb_mem_dump_reader.sv
// tb/tb_mem_dump_reader.sv - directed vector bench for mem_dump_reader with a behavioural BRAM
module tb_mem_dump_reader;

    logic        clk = 1'b0;
    logic        reset, start, m_ready;
    logic [10:0] first_addr, last_addr, raddr, m_addr;
    logic [71:0] rdata, m_data, checksum;
    logic        m_valid, m_last, busy, done;

    logic [71:0] mem [2048];
    int          n_vec = 0;
    int          n_bad = 0;

    typedef struct {
        logic [10:0] first;
        logic [10:0] last;
        int          pct;
        int          n;
        logic [71:0] cks;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    always @(posedge clk) rdata <= mem[raddr];

    mem_dump_reader dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .raddr      (raddr),
        .rdata      (rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_addr     (m_addr),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_sweep(input vec_t v);
        int          k = 0;
        bit          got_done = 0;
        bit          hold = 0;
        logic [71:0] hold_data;
        logic [10:0] hold_addr, exp_a;
        logic        hold_last;

        @(negedge clk);
        first_addr = v.first;
        last_addr  = v.last;
        start      = 1'b1;
        m_ready    = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 20000 && !got_done; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 0) chk("busy_after_start", busy, 1'b1);
            if (c == 1) chk("raddr_first", raddr, v.first);
            if (c == 2) chk("valid_latency_lo", m_valid, 1'b0);
            if (c == 3) chk("valid_latency_hi", m_valid, 1'b1);
            if (dut.occ > 2) chk("occupancy", dut.occ, 2);
            if (hold) begin
                chk("stall_valid", m_valid, 1'b1);
                chk("stall_data", m_data, hold_data);
                chk("stall_addr", m_addr, hold_addr);
                chk("stall_last", m_last, hold_last);
            end
            if (done) begin
                got_done = 1;
                m_ready  = 1'b0;
                chk("beat_count", k, v.n);
                chk("checksum", checksum, v.cks);
                chk("busy_at_done", busy, 1'b0);
                if (v.pct == 100) chk("done_cycle", c, v.n + 3);
                start      = 1'b1;
                first_addr = v.first + 11'd3;
            end else begin
                m_ready = ($urandom_range(99) < v.pct);
                if (m_valid && m_ready) begin
                    exp_a = v.first + 11'(k);
                    chk("beat_addr", m_addr, exp_a);
                    chk("beat_data", m_data, mem[exp_a]);
                    chk("beat_last", m_last, (k == v.n - 1));
                    k++;
                    hold = 0;
                end else if (m_valid) begin
                    hold      = 1;
                    hold_data = m_data;
                    hold_addr = m_addr;
                    hold_last = m_last;
                end else begin
                    hold = 0;
                end
            end
        end
        chk("sweep_timeout", got_done, 1'b1);
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse_width", done, 1'b0);
        chk("start_in_done_ignored", busy, 1'b0);
        chk("checksum_hold", checksum, v.cks);
    endtask

    initial begin
        int  k;
        bit  pulsed;
        int  done_seen;

        for (int i = 0; i < 2048; i++) mem[i] = 72'(i);
        mem[5] = 72'hAB;

        // XOR(0..2047) is 0; word 5 patched to AB gives 5^AB
        vecs[0] = '{first: 11'd0,    last: 11'd2047, pct: 100, n: 2048, cks: 72'hAE};
        vecs[1] = '{first: 11'd2046, last: 11'd1,    pct: 100, n: 4,    cks: 72'h0};
        vecs[2] = '{first: 11'd2045, last: 11'd2,    pct: 100, n: 6,    cks: 72'h7FF};
        vecs[3] = '{first: 11'd5,    last: 11'd5,    pct: 100, n: 1,    cks: 72'hAB};
        vecs[4] = '{first: 11'd7,    last: 11'd70,   pct: 100, n: 64,   cks: 72'h40};
        vecs[5] = '{first: 11'd7,    last: 11'd70,   pct: 30,  n: 64,   cks: 72'h40};

        reset      = 1'b1;
        start      = 1'b0;
        m_ready    = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        repeat (3) @(negedge clk);
        chk("rst_raddr", raddr, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_addr", m_addr, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_checksum", checksum, 0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_sweep(vecs[i]);

        // second start mid-sweep must be ignored; reset at beat 20 aborts silently
        @(negedge clk);
        first_addr = 11'd100;
        last_addr  = 11'd199;
        start      = 1'b1;
        m_ready    = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        k      = 0;
        pulsed = 0;
        for (int c = 0; c < 200 && k < 20; c++) begin
            start = 1'b0;
            if (k == 10 && !pulsed) begin
                start      = 1'b1;
                first_addr = 11'd500;
                last_addr  = 11'd510;
                pulsed     = 1;
            end
            if (m_valid) begin
                chk("busy_seq_addr", m_addr, 11'(100 + k));
                k++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("busy_seq_beats", k, 20);
        chk("busy_seq_busy", busy, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_m_valid", m_valid, 1'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_checksum", checksum, 0);
        done_seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) done_seen++;
            @(negedge clk);
        end
        chk("abort_no_done", done_seen, 0);
        m_ready = 1'b0;

        run_sweep(vecs[5]);
        run_sweep(vecs[1]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
